// File: rtl/apb_reg_bridge.sv
// apb_reg_bridge
// APB3 slave that turns each APB transfer into a single-cycle read or write
// strobe on the register-block bus. It holds the APB side in wait states until
// the register block answers with reg_ready. If no answer arrives within
// TIMEOUT cycles, the transfer completes with pslverr.
//
// Ports
//   clk, rst_b           clock, asynchronous active-low reset
//   psel/penable/pwrite  APB control
//   paddr/pwdata/pstrb   APB address, write data, byte strobes
//   prdata/pready/pslverr APB response (registered)
//   reg_addr/reg_wdata/reg_wstrb  register-bus request, held for the whole access
//   reg_re/reg_we        one-cycle register read/write strobes
//   reg_rdata/reg_ready  register-block response
//
// State | meaning
// IDLE  | waiting for an APB setup phase
// ISSUE | strobe cycle; reg_ready is already sampled here
// WAIT  | strobes low, waiting for reg_ready or timeout
// RESP  | pready pulse for exactly one cycle
module apb_reg_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W/8-1:0] pstrb,
  output logic [DATA_W-1:0]   prdata,
  output logic                pready,
  output logic                pslverr,
  output logic [ADDR_W-1:0]   reg_addr,
  output logic                reg_re,
  output logic                reg_we,
  output logic [DATA_W-1:0]   reg_wdata,
  output logic [DATA_W/8-1:0] reg_wstrb,
  input  logic [DATA_W-1:0]   reg_rdata,
  input  logic                reg_ready
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_write;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                w_setup;
  logic                w_misalign;
  logic                w_zero_strb;
  logic                w_timeout;
  logic                w_re_nxt;
  logic                w_we_nxt;
  logic                w_pready_nxt;
  logic                w_pslverr_nxt;
  logic [DATA_W-1:0]   w_prdata_nxt;

  assign w_setup     = psel & ~penable;
  assign w_misalign  = |paddr[1:0];
  assign w_zero_strb = pwrite & ~(|pstrb);
  // r_cnt holds the number of ISSUE/WAIT cycles already completed, so the
  // incremented value is the count including the current cycle.
  assign w_cnt_inc   = (r_cnt >= CNT_W'(TIMEOUT)) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_timeout   = (w_cnt_inc >= CNT_W'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_re_nxt      = 1'b0;
    w_we_nxt      = 1'b0;
    w_pready_nxt  = 1'b0;
    w_pslverr_nxt = 1'b0;
    w_prdata_nxt  = '0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_setup) begin
          if (w_misalign) begin
            w_state_nxt   = S_RESP;
            w_pready_nxt  = 1'b1;
            w_pslverr_nxt = 1'b1;
          end else if (w_zero_strb) begin
            w_state_nxt  = S_RESP;
            w_pready_nxt = 1'b1;
          end else begin
            w_state_nxt = S_ISSUE;
            w_re_nxt    = ~pwrite;
            w_we_nxt    = pwrite;
          end
        end
      end
      S_ISSUE, S_WAIT: begin
        // A ready in the same cycle the count expires still wins.
        if (reg_ready) begin
          w_state_nxt  = S_RESP;
          w_cnt_nxt    = '0;
          w_pready_nxt = 1'b1;
          w_prdata_nxt = r_write ? '0 : reg_rdata;
        end else if (w_timeout) begin
          w_state_nxt   = S_RESP;
          w_cnt_nxt     = '0;
          w_pready_nxt  = 1'b1;
          w_pslverr_nxt = 1'b1;
        end else begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = w_cnt_inc;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_cnt     <= '0;
      r_write   <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wstrb <= '0;
      reg_re    <= 1'b0;
      reg_we    <= 1'b0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
      prdata    <= '0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      reg_re  <= w_re_nxt;
      reg_we  <= w_we_nxt;
      pready  <= w_pready_nxt;
      pslverr <= w_pslverr_nxt;
      prdata  <= w_prdata_nxt;
      if (r_state == S_IDLE && w_setup) begin
        r_write   <= pwrite;
        reg_addr  <= paddr;
        reg_wdata <= pwdata;
        reg_wstrb <= pstrb;
      end
    end
  end

endmodule
